// File: rtl/go_turn_sequencer.sv
// go_turn_sequencer: turn sequencing, board ownership and packet exchange for one side of a networked 9x9 Go game
module go_turn_sequencer #(
    parameter logic LOCAL_COLOR = 1'b0,
    parameter int   UPD_TIMEOUT = 1000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         move_valid,
    input  logic [7:0]   move_in,
    output logic         move_accept,
    output logic         move_reject,
    output logic         upd_start,
    output logic [161:0] upd_board,
    output logic [7:0]   upd_move,
    output logic         upd_turn,
    input  logic         upd_ready,
    input  logic [161:0] upd_board_in,
    input  logic         tx_busy,
    output logic         tx_trigger,
    output logic [207:0] tx_bus,
    input  logic         rx_ready,
    input  logic [207:0] rx_bus,
    output logic         rx_err,
    output logic [161:0] board,
    output logic         turn,
    output logic         my_turn,
    output logic         game_over
);
    localparam int TW = $clog2(UPD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_LOCAL, S_UPDATE, S_SEND, S_REMOTE, S_OVER} state_t;
    localparam state_t S_INIT = LOCAL_COLOR ? S_REMOTE : S_LOCAL;

    state_t        r_state;
    logic [TW-1:0] r_tmo;
    logic [1:0]    r_pass;
    logic [7:0]    r_move;
    logic [7:0]    r_tx_seq;
    logic [7:0]    r_rx_seq;

    logic       w_pass;
    logic       w_in_range;
    logic [1:0] w_cell;
    logic       w_rx_ok;
    logic [1:0] w_rx_pass_cnt;
    logic       w_rx_unused;

    assign w_pass        = move_in == 8'hFF;
    assign w_in_range    = move_in <= 8'd80;
    assign w_cell        = 2'(board >> {move_in, 1'b0});
    assign w_rx_ok       = rx_bus[207:200] == 8'hA5 && rx_bus[199:192] == r_rx_seq;
    assign w_rx_pass_cnt = rx_bus[191:184] == 8'hFF ? r_pass + 2'd1 : 2'd0;
    assign w_rx_unused   = ^rx_bus[183:162];
    assign my_turn       = turn == LOCAL_COLOR && !game_over;

    // Turn FSM; every output is registered and pulses default low each cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_INIT;
            r_tmo       <= '0;
            r_pass      <= '0;
            r_move      <= '0;
            r_tx_seq    <= '0;
            r_rx_seq    <= '0;
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            upd_start   <= 1'b0;
            upd_board   <= '0;
            upd_move    <= '0;
            upd_turn    <= 1'b0;
            tx_trigger  <= 1'b0;
            tx_bus      <= '0;
            rx_err      <= 1'b0;
            board       <= '0;
            turn        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            move_accept <= 1'b0;
            move_reject <= 1'b0;
            upd_start   <= 1'b0;
            tx_trigger  <= 1'b0;
            rx_err      <= rx_ready && (r_state == S_LOCAL || r_state == S_UPDATE || r_state == S_SEND);
            case (r_state)
                S_LOCAL: begin
                    if (move_valid) begin
                        if (!w_pass && (!w_in_range || w_cell != 2'b00)) begin
                            move_reject <= 1'b1;
                        end else if (w_pass) begin
                            r_move      <= move_in;
                            r_pass      <= r_pass + 2'd1;
                            move_accept <= 1'b1;
                            r_state     <= S_SEND;
                        end else begin
                            r_move    <= move_in;
                            upd_board <= board;
                            upd_move  <= move_in;
                            upd_turn  <= turn;
                            upd_start <= 1'b1;
                            r_tmo     <= '0;
                            r_pass    <= '0;
                            r_state   <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (upd_ready) begin
                        board       <= upd_board_in;
                        move_accept <= 1'b1;
                        r_state     <= S_SEND;
                    end else if (r_tmo == TW'(UPD_TIMEOUT)) begin
                        move_reject <= 1'b1;
                        r_state     <= S_LOCAL;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_bus     <= {8'hA5, r_tx_seq, r_move, 22'b0, board};
                        tx_trigger <= 1'b1;
                        r_tx_seq   <= r_tx_seq + 8'd1;
                        turn       <= ~turn;
                        game_over  <= r_pass == 2'd2;
                        r_state    <= r_pass == 2'd2 ? S_OVER : S_REMOTE;
                    end
                end
                S_REMOTE: begin
                    if (rx_ready) begin
                        if (!w_rx_ok) begin
                            rx_err <= 1'b1;
                        end else begin
                            board     <= rx_bus[161:0];
                            r_rx_seq  <= r_rx_seq + 8'd1;
                            turn      <= ~turn;
                            r_pass    <= w_rx_pass_cnt;
                            game_over <= w_rx_pass_cnt == 2'd2;
                            r_state   <= w_rx_pass_cnt == 2'd2 ? S_OVER : S_LOCAL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_go_turn_sequencer.sv
// tb_go_turn_sequencer: directed checks of local moves, rejects, remote packets, passes, backpressure and reset
module tb_go_turn_sequencer;
    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         move_valid = 1'b0;
    logic [7:0]   move_in = '0;
    logic         move_accept, move_reject, upd_start, upd_turn;
    logic [161:0] upd_board;
    logic [7:0]   upd_move;
    logic         upd_ready = 1'b0;
    logic [161:0] upd_board_in = '0;
    logic         tx_busy = 1'b0;
    logic         tx_trigger;
    logic [207:0] tx_bus;
    logic         rx_ready = 1'b0;
    logic [207:0] rx_bus = '0;
    logic         rx_err;
    logic [161:0] board;
    logic         turn, my_turn, game_over;

    int total = 0;
    int bad = 0;
    int trig_cnt;
    logic [161:0] b1, b2;

    go_turn_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .move_valid(move_valid), .move_in(move_in),
        .move_accept(move_accept), .move_reject(move_reject),
        .upd_start(upd_start), .upd_board(upd_board), .upd_move(upd_move), .upd_turn(upd_turn),
        .upd_ready(upd_ready), .upd_board_in(upd_board_in),
        .tx_busy(tx_busy), .tx_trigger(tx_trigger), .tx_bus(tx_bus),
        .rx_ready(rx_ready), .rx_bus(rx_bus), .rx_err(rx_err),
        .board(board), .turn(turn), .my_turn(my_turn), .game_over(game_over)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [207:0] pkt(input logic [7:0] h, input logic [7:0] s, input logic [7:0] m, input logic [161:0] b);
        return {h, s, m, 22'b0, b};
    endfunction

    initial begin
        b1 = '0;
        b1[81:80] = 2'b01;
        b2 = b1;
        b2[61:60] = 2'b10;
        step();
        step();
        rst_in = 1'b0;
        chk("rst_board", board, 0);
        chk("rst_turn", turn, 0);
        chk("rst_my_turn", my_turn, 1);
        chk("rst_game_over", game_over, 0);
        chk("rst_tx_bus", tx_bus, 0);
        chk("rst_upd_board", upd_board, 0);
        // local move 40, updater answers after 5 cycles
        move_valid = 1'b1;
        move_in = 8'd40;
        step();
        move_valid = 1'b0;
        chk("lm_upd_start", upd_start, 1);
        chk("lm_upd_move", upd_move, 40);
        chk("lm_upd_board", upd_board, 0);
        chk("lm_upd_turn", upd_turn, 0);
        step();
        chk("lm_upd_start_width", upd_start, 0);
        step();
        step();
        step();
        upd_ready = 1'b1;
        upd_board_in = b1;
        step();
        upd_ready = 1'b0;
        chk("lm_accept", move_accept, 1);
        chk("lm_board", board, b1);
        chk("lm_cell40", board[81:80], 2'b01);
        chk("lm_no_trig_yet", tx_trigger, 0);
        step();
        chk("lm_trigger", tx_trigger, 1);
        chk("lm_tx_hdr", tx_bus[207:184], 24'hA50028);
        chk("lm_tx_pad", tx_bus[183:162], 0);
        chk("lm_tx_board", tx_bus[161:0], b1);
        chk("lm_turn", turn, 1);
        chk("lm_my_turn", my_turn, 0);
        chk("lm_accept_width", move_accept, 0);
        move_valid = 1'b1;
        move_in = 8'd10;
        step();
        move_valid = 1'b0;
        chk("lm_trigger_width", tx_trigger, 0);
        chk("remote_ignores_move_rej", move_reject, 0);
        chk("remote_ignores_move_upd", upd_start, 0);
        // remote packets
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA4, 8'h00, 8'd30, b2);
        step();
        rx_ready = 1'b0;
        chk("rx_bad_hdr_err", rx_err, 1);
        chk("rx_bad_hdr_board", board, b1);
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA5, 8'h01, 8'd30, b2);
        step();
        rx_ready = 1'b0;
        chk("rx_bad_seq_err", rx_err, 1);
        chk("rx_bad_seq_board", board, b1);
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA5, 8'h00, 8'd30, b2);
        step();
        rx_ready = 1'b0;
        chk("rx_ok_err", rx_err, 0);
        chk("rx_ok_board", board, b2);
        chk("rx_ok_turn", turn, 0);
        chk("rx_ok_my_turn", my_turn, 1);
        // rx outside remote phase is discarded
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA5, 8'h01, 8'd30, b1);
        step();
        rx_ready = 1'b0;
        chk("rx_local_err", rx_err, 1);
        chk("rx_local_board", board, b2);
        // rejects
        move_valid = 1'b1;
        move_in = 8'd81;
        step();
        chk("rej81", move_reject, 1);
        chk("rej81_no_upd", upd_start, 0);
        move_in = 8'd40;
        step();
        move_valid = 1'b0;
        chk("rej_occupied", move_reject, 1);
        chk("rej_occupied_no_upd", upd_start, 0);
        step();
        chk("rej_width", move_reject, 0);
        // updater timeout
        move_valid = 1'b1;
        move_in = 8'd50;
        step();
        move_valid = 1'b0;
        chk("tmo_upd_start", upd_start, 1);
        chk("tmo_upd_board", upd_board, b2);
        for (int i = 0; i < 1000; i++) step();
        chk("tmo_not_early", move_reject, 0);
        step();
        chk("tmo_reject", move_reject, 1);
        chk("tmo_no_accept", move_accept, 0);
        chk("tmo_board", board, b2);
        // local pass under tx backpressure
        tx_busy = 1'b1;
        move_valid = 1'b1;
        move_in = 8'hFF;
        step();
        move_valid = 1'b0;
        chk("pass_accept", move_accept, 1);
        chk("pass_no_upd", upd_start, 0);
        trig_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            trig_cnt += int'(tx_trigger);
        end
        tx_busy = 1'b0;
        chk("bp_no_trig_while_busy", trig_cnt, 0);
        step();
        chk("bp_trigger", tx_trigger, 1);
        chk("bp_tx_hdr", tx_bus[207:184], 24'hA501FF);
        chk("bp_tx_board", tx_bus[161:0], b2);
        chk("bp_turn", turn, 1);
        trig_cnt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            trig_cnt += int'(tx_trigger);
        end
        chk("bp_trig_once", trig_cnt, 1);
        chk("bp_no_over_yet", game_over, 0);
        // remote pass ends the game
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA5, 8'h01, 8'hFF, b2);
        step();
        rx_ready = 1'b0;
        chk("over_flag", game_over, 1);
        chk("over_rx_err", rx_err, 0);
        chk("over_turn", turn, 0);
        chk("over_my_turn", my_turn, 0);
        move_valid = 1'b1;
        move_in = 8'd20;
        rx_ready = 1'b1;
        rx_bus = pkt(8'hA5, 8'h02, 8'd20, b1);
        step();
        move_valid = 1'b0;
        rx_ready = 1'b0;
        chk("over_no_accept", move_accept, 0);
        chk("over_no_reject", move_reject, 0);
        chk("over_no_upd", upd_start, 0);
        chk("over_rx_ignored", rx_err, 0);
        chk("over_board", board, b2);
        // reset mid-update with a late updater answer
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst2_game_over", game_over, 0);
        chk("rst2_board", board, 0);
        move_valid = 1'b1;
        move_in = 8'd40;
        step();
        move_valid = 1'b0;
        chk("mid_upd_start", upd_start, 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        upd_ready = 1'b1;
        upd_board_in = b1;
        step();
        upd_ready = 1'b0;
        chk("mid_board", board, 0);
        chk("mid_accept", move_accept, 0);
        chk("mid_upd_start_low", upd_start, 0);
        chk("mid_upd_move", upd_move, 0);
        chk("mid_upd_board", upd_board, 0);
        chk("mid_tx_bus", tx_bus, 0);
        chk("mid_turn", turn, 0);
        chk("mid_my_turn", my_turn, 1);
        step();
        chk("mid_board_later", board, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/go_turn_sequencer.md
# go_turn_sequencer

Sequencer for one side of a two-board networked 9x9 Go game. It owns the authoritative board state and alternates between two phases. On the local turn it validates a player move, runs it through `board_updater`, and transmits the result as a 208-bit packet over the UART link. On the remote turn it waits for the opponent's packet, checks it, and adopts the received board. It sits between the move source (switches or cursor), `board_updater`, `tx`/`rx`, and `display`.

## Interface
- `LOCAL_COLOR`, default 1'b0: colour this board plays. 0 = black, which moves first; 1 = white.
- `UPD_TIMEOUT`, default 1000: maximum cycles to wait for `upd_ready` after `upd_start`.
- `clk_in` in 1: system clock (65 MHz).
- `rst_in` in 1: reset, asynchronous, active-high.
- `move_valid` in 1: one-cycle strobe; `move_in` is valid.
- `move_in` in 8: cell index row*9+col (0..80); 8'hFF = pass.
- `move_accept` out 1: one-cycle pulse; local move committed.
- `move_reject` out 1: one-cycle pulse; local move refused.
- `upd_start` out 1: one-cycle start pulse to `board_updater`.
- `upd_board` out 162: board presented to the updater.
- `upd_move` out 8: move presented to the updater.
- `upd_turn` out 1: colour presented to the updater.
- `upd_ready` in 1: updater done.
- `upd_board_in` in 162: updated board from the updater.
- `tx_busy` in 1: transmitter busy.
- `tx_trigger` out 1: one-cycle send pulse.
- `tx_bus` out 208: outgoing packet.
- `rx_ready` in 1: one-cycle strobe; `rx_bus` holds a received packet.
- `rx_bus` in 208: received packet.
- `rx_err` out 1: one-cycle pulse; packet discarded.
- `board` out 162: committed board. Cell i occupies bits [2i+1:2i]: 00 empty, 01 black, 10 white.
- `turn` out 1: colour to move.
- `my_turn` out 1: high when `turn == LOCAL_COLOR` and `game_over` is low.
- `game_over` out 1: sticky flag; set after two consecutive passes.

## Operation
- Packet layout: [207:200] = 8'hA5, [199:192] = sequence number, [191:184] = move, [183:162] = 0, [161:0] = board.
- States: S_LOCAL, S_UPDATE, S_SEND, S_REMOTE, S_OVER.
  - Reset state is S_LOCAL when LOCAL_COLOR = 0, else S_REMOTE.
- **S_LOCAL**, on `move_valid`:
  - `move_in` in 81..254: pulse `move_reject`; stay in S_LOCAL.
  - Target cell in `board` not 00: pulse `move_reject`; stay in S_LOCAL.
  - Pass (8'hFF): latch the move; `pass_cnt` += 1; pulse `move_accept`; go to S_SEND. The updater is not used.
  - Otherwise: drive `upd_board` = `board`, `upd_move` = `move_in`, `upd_turn` = `turn`; pulse `upd_start`; clear the timeout counter; clear `pass_cnt`; go to S_UPDATE.
- **S_UPDATE**:
  - On `upd_ready`: `board` <= `upd_board_in`; pulse `move_accept`; go to S_SEND.
  - Timeout counter reaches UPD_TIMEOUT: pulse `move_reject`; go to S_LOCAL; `board` is unchanged.
  - `upd_ready` and timeout in the same cycle: `upd_ready` wins.
- **S_SEND**:
  - Wait while `tx_busy` is high.
  - When `tx_busy` is low: load `tx_bus` = {8'hA5, `tx_seq`, latched move, 22'b0, `board`}; pulse `tx_trigger`; `tx_seq` += 1 (wraps 255 to 0); toggle `turn`.
  - Next state: S_OVER if `pass_cnt` == 2, else S_REMOTE.
- **S_REMOTE**, on `rx_ready`:
  - Header must be 8'hA5 and sequence must equal `rx_seq`; otherwise pulse `rx_err` and stay in S_REMOTE.
  - Valid packet: `board` <= `rx_bus`[161:0]; `rx_seq` += 1 (wraps); toggle `turn`.
  - Received move = 8'hFF: `pass_cnt` += 1. Any other move: `pass_cnt` = 0.
  - Next state: S_OVER if `pass_cnt` reaches 2, else S_LOCAL.
- **S_OVER**: terminal until reset. `game_over` = 1; `move_valid` and `rx_ready` are ignored.
- `move_valid` outside S_LOCAL: ignored, no pulse.
- `rx_ready` outside S_REMOTE and S_OVER: discarded with an `rx_err` pulse.
- `upd_board`, `upd_move` and `upd_turn` hold their values from `upd_start` until the next `upd_start`.
- `tx_bus` holds its value from `tx_trigger` until the next `tx_trigger`.
- Reset (any state, mid-update or mid-send):
  - All outputs 0: `board`, `turn`, `game_over`, `tx_bus`, upd_* buses, and all pulses.
  - `tx_seq`, `rx_seq`, `pass_cnt` = 0.
  - `my_turn` = !LOCAL_COLOR.
  - A late `upd_ready` after reset is ignored.

## Timing
- All state updates on the rising edge of `clk_in`; the only asynchronous path is `rst_in`.
- Local move, `move_valid` at cycle T:
  - `upd_start` and the upd_* buses at T+1.
  - `upd_ready` at cycle U: `board` and `move_accept` at U+1.
  - `tx_trigger` at U+2 at the earliest (when `tx_busy` is low).
- Pass: `move_accept` at T+1; `tx_trigger` at T+2 at the earliest.
- Reject (invalid or occupied move): `move_reject` at T+1.
- Timeout: `move_reject` UPD_TIMEOUT+1 cycles after `upd_start`.
- Remote packet, `rx_ready` at cycle R: `board`, `turn` and `rx_err` update at R+1; a new local move is accepted from R+1.
- `turn` toggles in the same edge as `tx_trigger`.
- Every pulse output is exactly one cycle wide.

## Test plan
- **Local move.** Reset with LOCAL_COLOR = 0; `move_in` = 40; updater returns a board with cell 40 = 01 after 5 cycles.
  - Required: `upd_start` at T+1; `move_accept` and `board`[81:80] = 01 at U+1.
  - Required: `tx_bus`[207:184] = {A5, 00, 28}; `turn` = 1; state S_REMOTE.
- **Rejects.** `move_in` = 81 → `move_reject`, no `upd_start`. `move_in` = 40 with cell 40 occupied → `move_reject`. Updater silent for 1000 cycles → `move_reject`, `board` unchanged.
- **Remote packets.**
  - Header 8'hA4 → `rx_err`, board unchanged.
  - Correct header, sequence 1 while `rx_seq` = 0 → `rx_err`.
  - Header A5, sequence 0 → `board` loads, `rx_seq` = 1, state S_LOCAL.
- **Double pass.** Local pass, then remote packet with move = FF → `game_over` = 1, state S_OVER; a following `move_valid` produces no pulse.
- **Tx backpressure.** `tx_busy` held high for 50 cycles after `move_accept` → `tx_trigger` fires exactly once, on the first cycle `tx_busy` is low.
- **Reset mid-update.** Assert `rst_in` in S_UPDATE, then `upd_ready` one cycle later → all outputs at reset values; `board` stays 0.
